// File: rtl/cub_alu_fetch_pkg.sv
// Shared types for the cube ALU instruction fetch block.
//   fetch_state_e : fetch sequencer states.
//   fetch_entry_t : instruction buffer entry {insn, pc}, laid out for the
//                   default 32-bit word / 8-bit address configuration. The
//                   buffer itself is width-generic and stores the same
//                   {insn, pc} packing.
package cub_alu_fetch_pkg;

  localparam int INSN_W_DEF = 32;
  localparam int AWID_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSN_W_DEF-1:0] insn;
    logic [AWID_DEF-1:0]   pc;
  } fetch_entry_t;

endpackage

// File: rtl/cub_alu_fetch_fifo.sv
// Synchronous instruction buffer with registered storage.
//   push_i/data_i : write an entry (accepted when not full, or full with pop)
//   pop_i         : drop the head entry (ignored when empty)
//   flush_i       : empty the buffer; wins over push and pop
//   data_o        : head entry; count_o/empty_o/full_o : occupancy
module cub_alu_fetch_fifo #(
  parameter  int FIFO_DEPTH = 4,
  parameter  int WIDTH      = 40,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(FIFO_DEPTH));
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    do_pop  = pop_i && !empty_o;
    // When full, the slot being written is the one being popped this cycle.
    do_push = push_i && (!full_o || do_pop);
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = data_i;
        wr_d        = wr_q + AW'(1);
      end
      if (do_pop) rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cub_alu_instr_fetch.sv
// Cube ALU instruction fetch initiator.
// Walks pc over an instruction window, issues req/gnt reads to the ALU
// instruction RAM (rvalid one cycle after gnt), buffers returned words and
// hands them to the decoder over valid/ready. Redirect flushes buffered and
// in-flight words and restarts at a new window.
//   fetch_start_i/base/len   : start a window (only while idle)
//   redirect_i/pc/len        : restart at a new window (only while busy)
//   alu_instr_*              : RAM read port
//   instr_valid_o/instr_o/instr_pc_o/instr_ready_i : decoder handshake
//   busy_o : not idle;  done_o : window fully delivered (one cycle)
module cub_alu_instr_fetch #(
  parameter int INSN_WIDTH = 32,
  parameter int IRAM_AWID  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_start_i,
  input  logic [IRAM_AWID-1:0]  fetch_base_i,
  input  logic [IRAM_AWID:0]    fetch_len_i,
  input  logic                  redirect_i,
  input  logic [IRAM_AWID-1:0]  redirect_pc_i,
  input  logic [IRAM_AWID:0]    redirect_len_i,
  output logic                  alu_instr_req_o,
  input  logic                  alu_instr_gnt_i,
  output logic [IRAM_AWID-1:0]  alu_instr_addr_o,
  input  logic [INSN_WIDTH-1:0] alu_instr_rdata_i,
  input  logic                  alu_instr_rvalid_i,
  output logic                  instr_valid_o,
  output logic [INSN_WIDTH-1:0] instr_o,
  output logic [IRAM_AWID-1:0]  instr_pc_o,
  input  logic                  instr_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);
  import cub_alu_fetch_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = INSN_WIDTH + IRAM_AWID;

  fetch_state_e         state_q, state_d;
  logic [IRAM_AWID-1:0] pc_q, pc_d, iss_pc_q, iss_pc_d;
  logic [IRAM_AWID:0]   rem_q, rem_d;
  logic                 out_q, out_d, kill_q, kill_d;

  logic [EW-1:0]        head;
  logic [CW-1:0]        fifo_cnt;
  logic                 fifo_empty, fifo_full;
  logic                 req, grant, redir, rsp, push, pop, done;

  cub_alu_fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  ({alu_instr_rdata_i, iss_pc_q}),
    .pop_i   (pop),
    .flush_i (redir),
    .data_o  (head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Credit counts the in-flight word so a buffer slot is always waiting for
  // every rvalid; only registered terms feed req, so req never depends on gnt.
  assign req   = (state_q == FETCH) && (rem_q != '0) &&
                 ((fifo_cnt + CW'(out_q)) < CW'(FIFO_DEPTH));
  assign grant = req && alu_instr_gnt_i;
  assign redir = redirect_i && (state_q != IDLE);
  assign rsp   = alu_instr_rvalid_i && out_q;
  assign push  = rsp && !kill_q && !redir;
  assign pop   = !fifo_empty && instr_ready_i;
  assign done  = (state_q == DRAIN) && !out_q && fifo_empty && !redir;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rem_d    = rem_q;
    out_d    = out_q;
    kill_d   = kill_q;
    iss_pc_d = iss_pc_q;
    if (redir) begin
      pc_d    = redirect_pc_i;
      rem_d   = redirect_len_i;
      state_d = (redirect_len_i == '0) ? DRAIN : FETCH;
      // A grant taken alongside the redirect belongs to the old window.
      out_d   = grant;
      kill_d  = grant;
      if (grant) iss_pc_d = pc_q;
    end else begin
      if (grant) begin
        pc_d     = pc_q + IRAM_AWID'(1);
        rem_d    = rem_q - (IRAM_AWID+1)'(1);
        out_d    = 1'b1;
        kill_d   = 1'b0;
        iss_pc_d = pc_q;
        if (rem_q == (IRAM_AWID+1)'(1)) state_d = DRAIN;
      end else if (rsp) begin
        out_d  = 1'b0;
        kill_d = 1'b0;
      end
      case (state_q)
        IDLE: if (fetch_start_i) begin
          pc_d    = fetch_base_i;
          rem_d   = fetch_len_i;
          state_d = (fetch_len_i == '0) ? DRAIN : FETCH;
        end
        DRAIN:   if (done) state_d = IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      rem_q    <= '0;
      out_q    <= 1'b0;
      kill_q   <= 1'b0;
      iss_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rem_q    <= rem_d;
      out_q    <= out_d;
      kill_q   <= kill_d;
      iss_pc_q <= iss_pc_d;
    end
  end

  assign alu_instr_req_o  = req;
  assign alu_instr_addr_o = pc_q;
  assign instr_valid_o    = !fifo_empty;
  assign instr_o          = head[EW-1:IRAM_AWID];
  assign instr_pc_o       = head[IRAM_AWID-1:0];
  assign busy_o           = (state_q != IDLE);
  assign done_o           = done;

endmodule

// File: doc/cub_alu_instr_fetch.md
# cub_alu_instr_fetch

ALU instruction fetch initiator for the MU cube ALU. It is the requesting end of the ALU instruction RAM read port (req/gnt/rvalid). It walks a program counter over a programmed instruction window, buffers returned words in a small FIFO, and presents them to the ALU decoder with a valid/ready handshake. It also supports redirect (jump/loop restart) with flush of buffered and in-flight words.

## Interface
- INSN_WIDTH, 32, instruction word width
- IRAM_AWID, 8, instruction RAM address width
- FIFO_DEPTH, 4, instruction buffer entries (power of two, ≥2)
- clk  in  1  clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- fetch_start_i  in  1  start pulse; ignored unless idle
- fetch_base_i  in  IRAM_AWID  first instruction address
- fetch_len_i  in  IRAM_AWID+1  instruction count, 0..2^IRAM_AWID
- redirect_i  in  1  restart at new window; ignored when idle
- redirect_pc_i  in  IRAM_AWID  redirect address
- redirect_len_i  in  IRAM_AWID+1  redirect instruction count
- alu_instr_req_o  out  1  read request to RAM
- alu_instr_gnt_i  in  1  RAM accepts request this cycle
- alu_instr_addr_o  out  IRAM_AWID  read address
- alu_instr_rdata_i  in  INSN_WIDTH  read data
- alu_instr_rvalid_i  in  1  read data valid, one cycle after gnt
- instr_valid_o  out  1  decoder-side valid
- instr_o  out  INSN_WIDTH  instruction word
- instr_pc_o  out  IRAM_AWID  address of instr_o
- instr_ready_i  in  1  decoder accepts
- busy_o  out  1  not idle
- done_o  out  1  one-cycle pulse when the window is fully delivered

## Operation
- States are IDLE, FETCH and DRAIN.
- IDLE:
  - On fetch_start_i, load pc=fetch_base_i and remaining=fetch_len_i, then go to FETCH.
  - If fetch_len_i=0, go straight to DRAIN. No request is issued, and done_o pulses the following cycle.
- FETCH:
  - alu_instr_req_o = remaining≠0 && (fifo_count + outstanding < FIFO_DEPTH).
  - alu_instr_addr_o = pc.
  - Credit terms are registered values only.
  - On req && gnt: pc increments modulo 2^IRAM_AWID (255→0 wraps), remaining decrements, and outstanding sets.
  - When the last grant is taken, go to DRAIN.
- DRAIN:
  - Wait until outstanding=0 and the FIFO is empty.
  - Then pulse done_o and return to IDLE.
- Response handling:
  - alu_instr_rvalid_i with outstanding=1 and no kill pushes {rdata, issue pc} into the FIFO and clears outstanding.
  - If a new gnt arrives in the same cycle, outstanding stays 1.
  - An rvalid with outstanding=0, or a killed rvalid, is dropped.
- Request rules:
  - Once asserted, req and addr are held until gnt unless a redirect occurs.
  - A refused request (gnt=0, e.g. RAM bank busy with a fill) simply retries.
- Redirect in FETCH or DRAIN:
  - The FIFO is flushed.
  - Any in-flight word is marked killed; its rvalid next cycle is dropped.
  - pc and remaining are loaded from the redirect inputs, and the state goes to FETCH, or to DRAIN if the length is 0.
  - Redirect has priority over gnt and rvalid in the same cycle; a gnt in that cycle still creates a killed outstanding.
- Start while busy is ignored.
- Decoder side:
  - instr_valid_o = FIFO not empty; instr_o and instr_pc_o come from the FIFO head.
  - A pop occurs on valid && ready.
  - A simultaneous push and pop is allowed, including when the FIFO is full-at-pop.
- busy_o = (state≠IDLE).

## Timing
- Reset values: req 0, addr 0, instr_valid 0, instr 0, instr_pc 0, busy 0, done 0; pc, remaining and outstanding are all 0; state is IDLE.
- Start to first req: 1 cycle (req asserts in the cycle after the start pulse).
- gnt to FIFO push: 1 cycle (rvalid). Push to instr_valid_o: 1 cycle (registered FIFO). gnt to instr_valid_o is therefore 2 cycles.
- Throughput: one instruction per cycle with a ready decoder and gnt=1 every cycle (DEPTH=4).
- Backpressure: req deasserts once fifo_count+outstanding reaches FIFO_DEPTH. No word is ever lost.
- done_o: the cycle after the last pop, with outstanding=0.
- Reset mid-operation returns all state and outputs to reset values on the next edge. Any pending rvalid arrives with outstanding=0 and is dropped.

## Structure
- Package cub_alu_fetch_pkg holds the fetch state enum (IDLE, FETCH, DRAIN) and the FIFO entry struct {insn, pc}.
- Sub-module cub_alu_fetch_fifo is a synchronous FIFO with parameters FIFO_DEPTH and entry width. It provides push, pop, flush, count, empty and full; flush has priority over push.
- The top level contains the FSM, pc/remaining counters, outstanding/kill flags and the credit logic.

## Test plan
- Streaming window: base=0x10, len=8, gnt=1 always, ready=1 → 8 requests at 0x10..0x17 on consecutive cycles; instr_pc_o takes 0x10..0x17 in order; done_o pulses once; busy_o then drops.
- Stall and backpressure: len=6, ready=0 → req stops after 4 grants; raise ready → remaining 2 fetched; all 6 delivered in order.
- Grant refusal: gnt=0 for 3 cycles on addr 0x80 → req and addr stay at 0x80 for the whole refusal; no pc advance and no rvalid-driven push until the grant is taken.
- Wrap: base=0xFE, len=4 → addresses 0xFE, 0xFF, 0x00, 0x01.
- Redirect with in-flight word: redirect pc=0x40, len=2, in the cycle after a gnt → the killed rvalid is dropped, the FIFO is empty, and the next delivered pcs are 0x40, 0x41.
- Edge cases: len=0 → no req, done_o after 1 cycle; start during FETCH is ignored; rst_n low mid-window → all outputs reset at the next edge.
